// File: rtl/glitch_sweep_ctrl.sv
// rtl/glitch_sweep_ctrl.sv - glitch attempt sequencer with delay sweep
module glitch_sweep_ctrl #(
  parameter int DW = 16,
  parameter int PW = 8
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_delay_start,
  input  logic [DW-1:0] cfg_delay_end,
  input  logic [PW-1:0] cfg_delay_step,
  input  logic [PW-1:0] cfg_width,
  input  logic [PW-1:0] cfg_cooldown,
  output logic          rst_en,
  input  logic          rst_ready,
  output logic          glitch_o,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] attempt,
  output logic [DW-1:0] cur_delay
);

  localparam int DW1 = DW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_REQ, S_RST_WAIT, S_DELAY, S_PULSE, S_COOL, S_DONE
  } state_t;

  state_t state, next_state;

  logic [DW-1:0] cnt;
  logic [DW-1:0] sh_end;
  logic [PW-1:0] sh_step;
  logic [PW-1:0] sh_width;
  logic [PW-1:0] sh_cool;

  logic [PW-1:0] width_last;
  logic [DW:0]   next_delay;
  logic          delay_hit;
  logic          pulse_last;
  logic          cool_last;
  logic          sweep_end;
  logic          abort_hit;

  // Sweep bookkeeping: width 0 acts as 1, next delay computed one bit wider so it cannot wrap
  always_comb begin
    width_last = (sh_width == '0) ? '0 : sh_width - PW'(1);
    next_delay = {1'b0, cur_delay} + DW1'(sh_step);
    delay_hit  = (cnt == cur_delay);
    pulse_last = (cnt == DW'(width_last));
    cool_last  = (cnt == DW'(sh_cool));
    sweep_end  = (sh_step == '0) || (next_delay > {1'b0, sh_end});
    abort_hit  = abort && (state != S_IDLE);
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    next_state = state;
    if (abort_hit) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start) next_state = S_RST_REQ;
        S_RST_REQ:  next_state = S_RST_WAIT;
        S_RST_WAIT: if (rst_ready) next_state = S_DELAY;
        S_DELAY:    if (delay_hit) next_state = S_PULSE;
        S_PULSE:    if (pulse_last) next_state = S_COOL;
        S_COOL:     if (cool_last) next_state = sweep_end ? S_DONE : S_RST_REQ;
        S_DONE:     next_state = S_IDLE;
        default:    next_state = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from state
  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    rst_en = (state == S_RST_REQ);
  end

  // Glitch pulse registered so it is high exactly during PULSE and glitch-free
  always_ff @(posedge clk_in) begin
    if (rst) glitch_o <= 1'b0;
    else     glitch_o <= (next_state == S_PULSE);
  end

  // Counter, attempt/delay tracking and shadow config
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt       <= '0;
      attempt   <= '0;
      cur_delay <= '0;
      sh_end    <= '0;
      sh_step   <= '0;
      sh_width  <= '0;
      sh_cool   <= '0;
    end else if (abort_hit) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh_end    <= cfg_delay_end;
            sh_step   <= cfg_delay_step;
            sh_width  <= cfg_width;
            sh_cool   <= cfg_cooldown;
            cur_delay <= cfg_delay_start;
            attempt   <= '0;
            cnt       <= '0;
          end
        end
        S_RST_WAIT: begin
          if (rst_ready) cnt <= '0;
        end
        S_DELAY: begin
          if (delay_hit) cnt <= '0;
          else           cnt <= cnt + DW'(1);
        end
        S_PULSE: begin
          if (pulse_last) cnt <= '0;
          else            cnt <= cnt + DW'(1);
        end
        S_COOL: begin
          if (cool_last) begin
            cnt     <= '0;
            attempt <= attempt + DW'(1);
            if (!sweep_end) cur_delay <= next_delay[DW-1:0];
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
